// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
//   cla_op_t        : operation carried down the pipe (ADD, SUB, SLT)
//   cla_num_groups  : number of lookahead groups for a WIDTH/GROUP pair
//   cla_width_ok    : elaboration-time legality check of WIDTH/GROUP
// -----------------------------------------------------------------------------
package cla_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      SLT = 2'd2
   } cla_op_t;

   // Number of GROUP-bit lookahead groups covering WIDTH bits.
   function automatic int cla_num_groups(input int width, input int group);
      return width / group;
   endfunction

   // WIDTH must be a positive whole multiple of a positive GROUP.
   function automatic bit cla_width_ok(input int width, input int group);
      return (group > 0) && (width >= group) && ((width % group) == 0);
   endfunction

endpackage

// File: rtl/cla_group_pg.sv
// -----------------------------------------------------------------------------
// cla_group_pg
// Per-bit and per-group generate/propagate for one GROUP-bit lookahead slice.
// Ports:
//   a, bx : operand slice (bx is B already conditionally inverted)
//   p, g  : per-bit propagate (a|bx) and generate (a&bx)
//   gp    : group propagate, AND of all per-bit p
//   gg    : group generate, g[msb] | p[msb]&g[msb-1] | ... | p[msb..1]&g[0]
// -----------------------------------------------------------------------------
module cla_group_pg
#(
   parameter int GROUP = 4
) (
   input  logic [GROUP-1:0] a,
   input  logic [GROUP-1:0] bx,
   output logic [GROUP-1:0] p,
   output logic [GROUP-1:0] g,
   output logic             gp,
   output logic             gg
);

   logic gg_s;

   assign p  = a | bx;
   assign g  = a & bx;
   assign gp = &p;

   // Group generate: folding from the LSB gives the nested sum-of-products form.
   always_comb begin
      gg_s = 1'b0;
      for (int i = 0; i < GROUP; i++) begin
         gg_s = g[i] | (p[i] & gg_s);
      end
   end

   assign gg = gg_s;

endmodule

// File: rtl/cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// cla_addsub_pipe
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready
// handshake and full-throughput backpressure.
//   Stage 1 registers the operands, the conditionally inverted B, the per-bit
//   p/g and the per-group P/G produced by NG cla_group_pg slices.
//   Stage 2 resolves group carries, ripples inside each group, and registers
//   sum plus cout/ovf/zero together with out_valid.
// Parameters:
//   WIDTH : operand/result width, a multiple of GROUP
//   GROUP : bits per lookahead group (GROUP == WIDTH gives a single group)
// Ports:
//   clk, reset           : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : input beat handshake (in_ready is combinational)
//   a, b, sub            : operands; sub=1 computes a-b
//   slt                  : only with CLA_SLT_EN; forces subtract, result is
//                          the signed a<b flag
//   out_valid / out_ready: result handshake
//   sum, cout, ovf, zero : result, carry out (sub: 1 = no borrow), signed
//                          overflow, result-is-zero
// Build option:
//   CLA_SLT_EN : adds the slt input and the set-less-than result path.
// -----------------------------------------------------------------------------
module cla_addsub_pipe
   import cla_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
`ifdef CLA_SLT_EN
   input  logic             slt,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NG = cla_num_groups(WIDTH, GROUP);

   if (!cla_width_ok(WIDTH, GROUP)) begin : g_width_err
      $error("cla_addsub_pipe: WIDTH (%0d) must be a positive multiple of GROUP (%0d)",
             WIDTH, GROUP);
   end

   // ---------------------------------------------------------------- handshake
   logic s1_valid_r;
   logic out_valid_r;
   logic s2_adv_s;
   logic s1_adv_s;

   // S2 can take new data when empty or draining; S1 likewise when S2 moves.
   assign s2_adv_s = (~out_valid_r) | out_ready;
   assign s1_adv_s = (~s1_valid_r) | s2_adv_s;
   assign in_ready = s1_adv_s;

   // ------------------------------------------------------------ stage 1 comb
   cla_op_t          op_s;
   logic             inv_s;
   logic [WIDTH-1:0] bx_s;
   logic [WIDTH-1:0] p_s;
   logic [WIDTH-1:0] g_s;
   logic [NG-1:0]    gp_s;
   logic [NG-1:0]    gg_s;

   // Decode the requested operation; set-less-than takes priority over sub.
   always_comb begin
      op_s = ADD;
`ifdef CLA_SLT_EN
      if (slt) begin
         op_s = SLT;
      end else if (sub) begin
         op_s = SUB;
      end else begin
         op_s = ADD;
      end
`else
      if (sub) begin
         op_s = SUB;
      end else begin
         op_s = ADD;
      end
`endif
   end

   // Subtraction is A + ~B + 1; the +1 enters later as the stage-2 carry-in.
   assign inv_s = (op_s != ADD);
   assign bx_s  = b ^ {WIDTH{inv_s}};

   for (genvar k = 0; k < NG; k++) begin : g_grp
      cla_group_pg #(
         .GROUP (GROUP)
      ) u_pg (
         .a  (a[k*GROUP +: GROUP]),
         .bx (bx_s[k*GROUP +: GROUP]),
         .p  (p_s[k*GROUP +: GROUP]),
         .g  (g_s[k*GROUP +: GROUP]),
         .gp (gp_s[k]),
         .gg (gg_s[k])
      );
   end

   // ------------------------------------------------------------ stage 1 regs
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] bx_r;
   logic [WIDTH-1:0] p_r;
   logic [WIDTH-1:0] g_r;
   logic [NG-1:0]    grp_p_r;
   logic [NG-1:0]    grp_g_r;
   cla_op_t          op_r;

   // Stage 1 register: operands, op and lookahead terms; holds while stalled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_r <= 1'b0;
         a_r        <= {WIDTH{1'b0}};
         bx_r       <= {WIDTH{1'b0}};
         p_r        <= {WIDTH{1'b0}};
         g_r        <= {WIDTH{1'b0}};
         grp_p_r    <= {NG{1'b0}};
         grp_g_r    <= {NG{1'b0}};
         op_r       <= ADD;
      end else if (s1_adv_s) begin
         s1_valid_r <= in_valid;
         a_r        <= a;
         bx_r       <= bx_s;
         p_r        <= p_s;
         g_r        <= g_s;
         grp_p_r    <= gp_s;
         grp_g_r    <= gg_s;
         op_r       <= op_s;
      end
   end

   // ------------------------------------------------------------ stage 2 comb
   logic             cin_s;
   logic [WIDTH-1:0] carry_s;
   logic             cout_s;
   logic             ovf_s;
   logic [WIDTH-1:0] raw_s;
   logic [WIDTH-1:0] sum_fin_s;
   logic             zero_s;

   // Carry-in is 1 for every subtracting operation.
   always_comb begin
      case (op_r)
         ADD:     cin_s = 1'b0;
         SUB:     cin_s = 1'b1;
         SLT:     cin_s = 1'b1;
         default: cin_s = 1'b0;
      endcase
   end

   // Group carries look ahead across groups; bit carries ripple inside a group
   // starting from that group's lookahead carry.
   always_comb begin : s2_carry
      logic c_v;
      logic cb_v;
      carry_s = {WIDTH{1'b0}};
      c_v     = cin_s;
      cb_v    = 1'b0;
      for (int k = 0; k < NG; k++) begin
         cb_v = c_v;
         for (int j = 0; j < GROUP; j++) begin
            carry_s[k*GROUP + j] = cb_v;
            cb_v = g_r[k*GROUP + j] | (p_r[k*GROUP + j] & cb_v);
         end
         c_v = grp_g_r[k] | (grp_p_r[k] & c_v);
      end
      cout_s = c_v;
   end

   assign raw_s = a_r ^ bx_r ^ carry_s;
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign ovf_s = carry_s[WIDTH-1] ^ cout_s;

   // Final result: raw sum, or the signed less-than flag for SLT.
   always_comb begin
      sum_fin_s = raw_s;
`ifdef CLA_SLT_EN
      if (op_r == SLT) begin
         sum_fin_s = {{(WIDTH-1){1'b0}}, raw_s[WIDTH-1] ^ ovf_s};
      end else begin
         sum_fin_s = raw_s;
      end
`endif
   end

   assign zero_s = ~|sum_fin_s;

   // ------------------------------------------------------------ stage 2 regs
   logic [WIDTH-1:0] sum_r;
   logic             cout_r;
   logic             ovf_r;
   logic             zero_r;

   // Stage 2 register: result and flags; frozen while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         sum_r       <= {WIDTH{1'b0}};
         cout_r      <= 1'b0;
         ovf_r       <= 1'b0;
         zero_r      <= 1'b0;
      end else if (s2_adv_s) begin
         out_valid_r <= s1_valid_r;
         sum_r       <= sum_fin_s;
         cout_r      <= cout_s;
         ovf_r       <= ovf_s;
         zero_r      <= zero_s;
      end
   end

   assign out_valid = out_valid_r;
   assign sum       = sum_r;
   assign cout      = cout_r;
   assign ovf       = ovf_r;
   assign zero      = zero_r;

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_cla_addsub_pipe
// Drives three instances (16/4, 32/4 and the single-group 8/8 case) and
// compares every result against plain-arithmetic expectations.
// -----------------------------------------------------------------------------
module tb_cla_addsub_pipe;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   logic        d16_in_valid, d16_in_ready, d16_sub, d16_out_valid, d16_out_ready;
   logic [15:0] d16_a, d16_b, d16_sum;
   logic        d16_cout, d16_ovf, d16_zero;
   logic        d32_in_valid, d32_in_ready, d32_sub, d32_out_valid, d32_out_ready;
   logic [31:0] d32_a, d32_b, d32_sum;
   logic        d32_cout, d32_ovf, d32_zero;
   logic        d8_in_valid, d8_in_ready, d8_sub, d8_out_valid, d8_out_ready;
   logic [7:0]  d8_a, d8_b, d8_sum;
   logic        d8_cout, d8_ovf, d8_zero;
`ifdef CLA_SLT_EN
   logic        d16_slt, d32_slt, d8_slt;
`endif

   cla_addsub_pipe #(.WIDTH(16), .GROUP(4)) u_d16 (
      .clk(clk), .reset(reset), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
      .a(d16_a), .b(d16_b), .sub(d16_sub),
`ifdef CLA_SLT_EN
      .slt(d16_slt),
`endif
      .out_valid(d16_out_valid), .out_ready(d16_out_ready), .sum(d16_sum),
      .cout(d16_cout), .ovf(d16_ovf), .zero(d16_zero));

   cla_addsub_pipe #(.WIDTH(32), .GROUP(4)) u_d32 (
      .clk(clk), .reset(reset), .in_valid(d32_in_valid), .in_ready(d32_in_ready),
      .a(d32_a), .b(d32_b), .sub(d32_sub),
`ifdef CLA_SLT_EN
      .slt(d32_slt),
`endif
      .out_valid(d32_out_valid), .out_ready(d32_out_ready), .sum(d32_sum),
      .cout(d32_cout), .ovf(d32_ovf), .zero(d32_zero));

   cla_addsub_pipe #(.WIDTH(8), .GROUP(8)) u_d8 (
      .clk(clk), .reset(reset), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
      .a(d8_a), .b(d8_b), .sub(d8_sub),
`ifdef CLA_SLT_EN
      .slt(d8_slt),
`endif
      .out_valid(d8_out_valid), .out_ready(d8_out_ready), .sum(d8_sum),
      .cout(d8_cout), .ovf(d8_ovf), .zero(d8_zero));

   // Reference: w-bit two's-complement add/sub with integer arithmetic.
   function automatic void ref_calc(input int w, input logic [63:0] a, input logic [63:0] b,
                                    input bit sub, input bit slt, output logic [63:0] s,
                                    output bit co, output bit ov, output bit z);
      logic [63:0] mask, bb, full, raw;
      longint      sa, sb;
      bit          dosub, less;
      mask  = (64'd1 << w) - 64'd1;
      dosub = sub | slt;
      bb    = dosub ? (~b & mask) : (b & mask);
      full  = (a & mask) + bb + {63'd0, dosub};
      raw   = full & mask;
      co    = full[w];
      if (dosub) ov = (a[w-1] != b[w-1]) && (raw[w-1] != a[w-1]);
      else       ov = (a[w-1] == b[w-1]) && (raw[w-1] != a[w-1]);
      sa    = a[w-1] ? longint'(a & mask) - (longint'(1) << w) : longint'(a & mask);
      sb    = b[w-1] ? longint'(b & mask) - (longint'(1) << w) : longint'(b & mask);
      less  = (sa < sb);
      s     = slt ? {63'd0, less} : raw;
      z     = (s == 64'd0);
   endfunction

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (d16_out_valid !== 1'b0 || d16_in_ready !== 1'b1 || d16_sum !== 16'd0 ||
          d16_cout !== 1'b0 || d16_ovf !== 1'b0 || d16_zero !== 1'b0) begin
         n_bad++;
         $display("FAIL reset16: got v=%b r=%b s=%h c=%b o=%b z=%b expected v=0 r=1 s=0 c=0 o=0 z=0",
                  d16_out_valid, d16_in_ready, d16_sum, d16_cout, d16_ovf, d16_zero);
      end
      n_cmp++;
      if (d32_out_valid !== 1'b0 || d32_in_ready !== 1'b1 || d32_sum !== 32'd0 ||
          d32_cout !== 1'b0 || d32_ovf !== 1'b0 || d32_zero !== 1'b0) begin
         n_bad++;
         $display("FAIL reset32: got v=%b r=%b s=%h c=%b o=%b z=%b expected v=0 r=1 s=0 c=0 o=0 z=0",
                  d32_out_valid, d32_in_ready, d32_sum, d32_cout, d32_ovf, d32_zero);
      end
      n_cmp++;
      if (d8_out_valid !== 1'b0 || d8_in_ready !== 1'b1 || d8_sum !== 8'd0) begin
         n_bad++;
         $display("FAIL reset8: got v=%b r=%b s=%h expected v=0 r=1 s=0",
                  d8_out_valid, d8_in_ready, d8_sum);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed16();
      logic [15:0] qa[$], qb[$];
      bit          qs[$], ql[$];
      logic [63:0] es;
      bit          eco, eov, ez;
      qa = '{16'h7FFF, 16'h0005, 16'h0000, 16'h8000, 16'hFFFF};
      qb = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'hFFFF};
      qs = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      ql = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CLA_SLT_EN
      qa.push_back(16'h8000); qb.push_back(16'h0001); qs.push_back(1'b0); ql.push_back(1'b1);
      qa.push_back(16'h0003); qb.push_back(16'h0002); qs.push_back(1'b0); ql.push_back(1'b1);
      qa.push_back(16'h0002); qb.push_back(16'h0003); qs.push_back(1'b0); ql.push_back(1'b1);
`endif
      for (int i = 0; i < 4; i++) begin
         qa.push_back(16'($urandom)); qb.push_back(16'($urandom));
         qs.push_back(1'($urandom_range(0, 1))); ql.push_back(1'b0);
      end
      for (int i = 0; i < qa.size(); i++) begin
         d16_a = qa[i]; d16_b = qb[i]; d16_sub = qs[i];
`ifdef CLA_SLT_EN
         d16_slt = ql[i];
`endif
         d16_in_valid = 1'b1; d16_out_ready = 1'b1;
         #1;
         n_cmp++;
         if (d16_in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL dir16_ready[%0d]: got %b expected 1", i, d16_in_ready);
         end
         @(posedge clk); #1;
         d16_in_valid = 1'b0;
         n_cmp++;
         if (d16_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL dir16_early[%0d]: got out_valid=%b expected 0", i, d16_out_valid);
         end
         @(posedge clk); #1;
         ref_calc(16, {48'd0, qa[i]}, {48'd0, qb[i]}, qs[i], ql[i], es, eco, eov, ez);
         n_cmp++;
         if (d16_out_valid !== 1'b1 || d16_sum !== es[15:0] || d16_cout !== eco ||
             d16_ovf !== eov || d16_zero !== ez) begin
            n_bad++;
            $display("FAIL dir16[%0d] a=%h b=%h sub=%b slt=%b: got v=%b s=%h c=%b o=%b z=%b expected v=1 s=%h c=%b o=%b z=%b",
                     i, qa[i], qb[i], qs[i], ql[i], d16_out_valid, d16_sum, d16_cout,
                     d16_ovf, d16_zero, es[15:0], eco, eov, ez);
         end
      end
   endtask

   task automatic test_carry_chain32();
      logic [31:0] qa[$], qb[$];
      bit          qs[$];
      logic [63:0] es;
      bit          eco, eov, ez;
      qa = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h80000000, 32'h7FFFFFFF, 32'h00000000};
      qb = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h7FFFFFFF, 32'h00000000};
      qs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         qa.push_back($urandom); qb.push_back($urandom); qs.push_back(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < qa.size(); i++) begin
         d32_a = qa[i]; d32_b = qb[i]; d32_sub = qs[i];
         d32_in_valid = 1'b1; d32_out_ready = 1'b1;
         @(posedge clk); #1;
         d32_in_valid = 1'b0;
         @(posedge clk); #1;
         ref_calc(32, {32'd0, qa[i]}, {32'd0, qb[i]}, qs[i], 1'b0, es, eco, eov, ez);
         n_cmp++;
         if (d32_out_valid !== 1'b1 || d32_sum !== es[31:0] || d32_cout !== eco ||
             d32_ovf !== eov || d32_zero !== ez) begin
            n_bad++;
            $display("FAIL chain32[%0d] a=%h b=%h sub=%b: got v=%b s=%h c=%b o=%b z=%b expected v=1 s=%h c=%b o=%b z=%b",
                     i, qa[i], qb[i], qs[i], d32_out_valid, d32_sum, d32_cout, d32_ovf,
                     d32_zero, es[31:0], eco, eov, ez);
         end
      end
   endtask

   task automatic test_single_group8();
      logic [7:0]  ta, tb;
      bit          ts;
      logic [63:0] es;
      bit          eco, eov, ez;
      for (int i = 0; i < 10; i++) begin
         ta = (i == 0) ? 8'hFF : 8'($urandom);
         tb = (i == 0) ? 8'h01 : 8'($urandom);
         ts = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         d8_a = ta; d8_b = tb; d8_sub = ts;
         d8_in_valid = 1'b1; d8_out_ready = 1'b1;
         @(posedge clk); #1;
         d8_in_valid = 1'b0;
         @(posedge clk); #1;
         ref_calc(8, {56'd0, ta}, {56'd0, tb}, ts, 1'b0, es, eco, eov, ez);
         n_cmp++;
         if (d8_out_valid !== 1'b1 || d8_sum !== es[7:0] || d8_cout !== eco ||
             d8_ovf !== eov || d8_zero !== ez) begin
            n_bad++;
            $display("FAIL group8[%0d] a=%h b=%h sub=%b: got v=%b s=%h c=%b o=%b z=%b expected v=1 s=%h c=%b o=%b z=%b",
                     i, ta, tb, ts, d8_out_valid, d8_sum, d8_cout, d8_ovf, d8_zero,
                     es[7:0], eco, eov, ez);
         end
      end
   endtask

   // Streams n beats through the 32-bit instance; rnd=0 uses ready 1,0,0,1.
   task automatic test_stream(input int n, input bit rnd);
      logic [31:0] eq_s[$];
      bit          eq_c[$], eq_o[$], eq_z[$];
      logic [31:0] ca, cb, h_sum;
      bit          cs, cl, new_beat, stall_prev, fire_in, fire_out, exp_ready;
      logic        h_c, h_o, h_z;
      logic [63:0] es;
      bit          eco, eov, ez;
      int          sent, rcv, occ, cyc;
      bit          pat [0:3];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      sent = 0; rcv = 0; occ = 0; cyc = 0;
      new_beat = 1'b1; stall_prev = 1'b0;
      ca = 32'd0; cb = 32'd0; cs = 1'b0; cl = 1'b0;
      h_sum = 32'd0; h_c = 1'b0; h_o = 1'b0; h_z = 1'b0;
      while ((rcv < n) && (cyc < 40 * n)) begin
         if (new_beat) begin
            ca = $urandom; cb = $urandom; cs = 1'($urandom_range(0, 1)); cl = 1'b0;
            if ($urandom_range(0, 4) == 0) cb = ca;
`ifdef CLA_SLT_EN
            cl = ($urandom_range(0, 3) == 0);
`endif
            new_beat = 1'b0;
         end
         d32_a = ca; d32_b = cb; d32_sub = cs;
`ifdef CLA_SLT_EN
         d32_slt = cl;
`endif
         d32_in_valid  = (sent < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
         d32_out_ready = rnd ? ($urandom_range(0, 2) != 0) : pat[cyc % 4];
         #1;
         exp_ready = !((occ == 2) && !d32_out_ready);
         n_cmp++;
         if (d32_in_ready !== exp_ready) begin
            n_bad++;
            $display("FAIL stream_in_ready cyc=%0d occ=%0d: got %b expected %b",
                     cyc, occ, d32_in_ready, exp_ready);
         end
         if (stall_prev) begin
            n_cmp++;
            if (d32_out_valid !== 1'b1 || d32_sum !== h_sum || d32_cout !== h_c ||
                d32_ovf !== h_o || d32_zero !== h_z) begin
               n_bad++;
               $display("FAIL stream_stall cyc=%0d: got v=%b s=%h expected v=1 s=%h held",
                        cyc, d32_out_valid, d32_sum, h_sum);
            end
         end
         if (d32_out_valid === 1'b1) begin
            n_cmp++;
            if (eq_s.size() == 0) begin
               n_bad++;
               $display("FAIL stream_spurious cyc=%0d: got out_valid=1 expected no pending result", cyc);
            end else if (d32_sum !== eq_s[0] || d32_cout !== eq_c[0] ||
                         d32_ovf !== eq_o[0] || d32_zero !== eq_z[0]) begin
               n_bad++;
               $display("FAIL stream_data #%0d: got s=%h c=%b o=%b z=%b expected s=%h c=%b o=%b z=%b",
                        rcv, d32_sum, d32_cout, d32_ovf, d32_zero, eq_s[0], eq_c[0], eq_o[0], eq_z[0]);
            end
         end
         fire_in    = d32_in_valid && d32_in_ready;
         fire_out   = d32_out_valid && d32_out_ready;
         stall_prev = d32_out_valid && !d32_out_ready;
         h_sum = d32_sum; h_c = d32_cout; h_o = d32_ovf; h_z = d32_zero;
         if (fire_in) begin
            ref_calc(32, {32'd0, ca}, {32'd0, cb}, cs, cl, es, eco, eov, ez);
            eq_s.push_back(es[31:0]); eq_c.push_back(eco); eq_o.push_back(eov); eq_z.push_back(ez);
            sent++; occ++; new_beat = 1'b1;
         end
         if (fire_out && (eq_s.size() != 0)) begin
            void'(eq_s.pop_front()); void'(eq_c.pop_front());
            void'(eq_o.pop_front()); void'(eq_z.pop_front());
            rcv++; occ--;
         end
         @(posedge clk); #1;
         cyc++;
      end
      d32_in_valid = 1'b0;
      n_cmp++;
      if (rcv != n) begin
         n_bad++;
         $display("FAIL stream_count: got %0d results expected %0d", rcv, n);
      end
   endtask

   task automatic test_reset_midflight();
      d32_out_ready = 1'b0;
      d32_in_valid  = 1'b1; d32_a = 32'h11111111; d32_b = 32'h22222222; d32_sub = 1'b0;
      @(posedge clk); #1;
      d32_a = 32'h33333333; d32_b = 32'h44444444;
      @(posedge clk); #1;
      d32_in_valid = 1'b0;
      n_cmp++;
      if (d32_in_ready !== 1'b0 || d32_out_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_fill: got in_ready=%b out_valid=%b expected 0 1", d32_in_ready, d32_out_valid);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (d32_out_valid !== 1'b0 || d32_in_ready !== 1'b1 || d32_sum !== 32'd0 ||
          d32_cout !== 1'b0 || d32_ovf !== 1'b0 || d32_zero !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_async: got v=%b r=%b s=%h c=%b o=%b z=%b expected v=0 r=1 s=0 c=0 o=0 z=0",
                  d32_out_valid, d32_in_ready, d32_sum, d32_cout, d32_ovf, d32_zero);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      d32_out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++;
         if (d32_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_stale[%0d]: got out_valid=%b expected 0", i, d32_out_valid);
         end
      end
   endtask

   initial begin
      d16_in_valid = 1'b0; d16_out_ready = 1'b1; d16_a = 16'd0; d16_b = 16'd0; d16_sub = 1'b0;
      d32_in_valid = 1'b0; d32_out_ready = 1'b1; d32_a = 32'd0; d32_b = 32'd0; d32_sub = 1'b0;
      d8_in_valid  = 1'b0; d8_out_ready  = 1'b1; d8_a  = 8'd0;  d8_b  = 8'd0;  d8_sub  = 1'b0;
`ifdef CLA_SLT_EN
      d16_slt = 1'b0; d32_slt = 1'b0; d8_slt = 1'b0;
`endif
      test_reset();
      @(posedge clk); #1;
      test_directed16();
      test_carry_chain32();
      test_single_group8();
      test_stream(8, 1'b0);
      test_stream(300, 1'b1);
      test_reset_midflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
